// File: rtl/tmds_pkg.sv
// tmds_pkg: shared constants and helpers for the TMDS serializer.
//   TMDS control symbols, clock-lane pattern generator, counter width helper.
package tmds_pkg;

  // TMDS control-period symbols indexed by {C1,C0}
  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  localparam int MAX_WORD_W = 64;

  // Clock-lane word: low half ones, high half zeros, so LSB-first
  // shifting gives word_w/2 high slots followed by word_w/2 low slots.
  function automatic logic [MAX_WORD_W-1:0] clk_pattern(input int word_w);
    logic [MAX_WORD_W-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_WORD_W; i++) begin
      if (i < word_w / 2) p[i] = 1'b1;
    end
    return p;
  endfunction

  // Width for a counter spanning 0..n-1 (at least one bit)
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tmds_serializer_fifo.sv
// tmds_word_fifo: synchronous symbol-group FIFO with occupancy output.
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
//   ready_o is registered from the next-state level, so a push is refused
//   while full even if a pop happens in the same cycle.
module tmds_word_fifo #(
  parameter int W     = 30,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     empty_o,
  output logic                     ready_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW:0]             wr_q, wr_d, rd_q, rd_d, lvl, lvl_d;
  logic                    ready_q, ready_d;
  logic                    do_push, do_pop;

  assign lvl     = wr_q - rd_q;
  assign empty_o = (lvl == '0);
  assign do_push = push_i && ready_q;
  assign do_pop  = pop_i && !empty_o;
  assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
  assign rd_d    = do_pop  ? rd_q + 1'b1 : rd_q;
  assign lvl_d   = wr_d - rd_d;
  assign ready_d = (lvl_d != FULL_LVL);

  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign ready_o = ready_q;
  assign level_o = lvl;

  // Pointer and ready registers; ready held low through reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/tmds_serializer.sv
// tmds_serializer: buffers pre-encoded TMDS symbol groups and shifts them out
//   BITS_PER_CLK bits per lane per clkt, LSB first, with a matching clock lane.
//   On starvation (enable=1, FIFO empty at load) IDLE_WORD is sent and the
//   sticky underflow flag is raised.
//   Optional macro TMDS_UNDERFLOW_CNT_EN adds a saturating 16-bit
//   underflow_cnt output counting starved loads.
module tmds_serializer
  import tmds_pkg::*;
#(
  parameter int                NCH          = 3,
  parameter int                WORD_W       = 10,
  parameter int                BITS_PER_CLK = 1,
  parameter int                FIFO_DEPTH   = 4,
  parameter logic [WORD_W-1:0] IDLE_WORD    = WORD_W'(CTRL_00)
) (
  input  logic                          clkt,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NCH*WORD_W-1:0]         in_data,
  input  logic                          clr_underflow,
  output logic [NCH*BITS_PER_CLK-1:0]   out_data,
  output logic [BITS_PER_CLK-1:0]       out_clk,
  output logic                          word_strobe,
  output logic                          underflow,
`ifdef TMDS_UNDERFLOW_CNT_EN
  output logic [15:0]                   underflow_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int                SLOTS    = WORD_W / BITS_PER_CLK;
  localparam int                PH_W     = cnt_w(SLOTS);
  localparam logic [PH_W-1:0]   LAST_PH  = PH_W'(SLOTS - 1);
  localparam logic [WORD_W-1:0] CLK_WORD = WORD_W'(clk_pattern(WORD_W));

  logic [PH_W-1:0]              phase_q, phase_d;
  logic                         load, pop, uf_event, fifo_empty;
  logic [NCH-1:0][WORD_W-1:0]   fifo_head;
  logic [NCH:0][WORD_W-1:0]     shreg_q, shreg_d;   // lane NCH = clock lane
  logic                         strobe_q, strobe_d;
  logic                         uf_q, uf_d;

  assign load     = (phase_q == LAST_PH);
  assign pop      = load && enable && !fifo_empty;
  assign uf_event = load && enable && fifo_empty;
  assign phase_d  = load ? '0 : phase_q + 1'b1;
  assign strobe_d = load;

  tmds_word_fifo #(
    .W     (NCH*WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clkt),
    .rst_n_i (rst_n),
    .push_i  (in_valid),
    .data_i  (in_data),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .ready_o (in_ready),
    .level_o (fifo_level)
  );

  // Data lanes: load head (or idle) on the load cycle, otherwise shift right
  for (genvar n = 0; n < NCH; n++) begin : g_lane
    assign shreg_d[n] = load ? (pop ? fifo_head[n] : IDLE_WORD)
                             : (shreg_q[n] >> BITS_PER_CLK);
    assign out_data[n*BITS_PER_CLK +: BITS_PER_CLK] = shreg_q[n][BITS_PER_CLK-1:0];
  end

  assign shreg_d[NCH] = load ? CLK_WORD : (shreg_q[NCH] >> BITS_PER_CLK);
  assign out_clk      = shreg_q[NCH][BITS_PER_CLK-1:0];

  // Sticky underflow: a starved load wins over a coincident clear
  always_comb begin
    uf_d = uf_q;
    if (uf_event)           uf_d = 1'b1;
    else if (clr_underflow) uf_d = 1'b0;
  end

  // Phase counter, shift registers, strobe and underflow state
  always_ff @(posedge clkt) begin
    if (!rst_n) begin
      phase_q  <= '0;
      shreg_q  <= '0;
      strobe_q <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      shreg_q  <= shreg_d;
      strobe_q <= strobe_d;
      uf_q     <= uf_d;
    end
  end

  assign word_strobe = strobe_q;
  assign underflow   = uf_q;

`ifdef TMDS_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating starved-load counter; increment over clear leaves 1
  always_comb begin
    ucnt_d = ucnt_q;
    if (uf_event && clr_underflow) ucnt_d = 16'd1;
    else if (uf_event) begin
      if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    end else if (clr_underflow) ucnt_d = '0;
  end

  // Counter register
  always_ff @(posedge clkt) begin
    if (!rst_n) ucnt_q <= '0;
    else        ucnt_q <= ucnt_d;
  end

  assign underflow_cnt = ucnt_q;
`endif

endmodule
